// File: rtl/ysyx_24080014_wbu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24080014_wbu_pkg
//  Brief    : Shared types and constants for the writeback unit: instruction
//             kinds, CSR control encodings, writable CSR addresses and the
//             writeback state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package ysyx_24080014_wbu_pkg;

    // Instruction kind carried from EXU; unlisted codes behave as ALU
    typedef enum logic [2:0] {
        KIND_ALU   = 3'd0,
        KIND_LOAD  = 3'd1,
        KIND_CSR   = 3'd2,
        KIND_ECALL = 3'd3,
        KIND_MRET  = 3'd4
    } wbu_kind_e;

    // Control request towards the CSR block
    typedef enum logic [1:0] {
        CSR_CTL_NONE  = 2'b00,
        CSR_CTL_ECALL = 2'b01,
        CSR_CTL_MRET  = 2'b10
    } csr_ctl_e;

    // The only CSRs the register file implements
    localparam logic [11:0] c_CSR_MSTATUS = 12'h300;
    localparam logic [11:0] c_CSR_MTVEC   = 12'h305;
    localparam logic [11:0] c_CSR_MEPC    = 12'h341;
    localparam logic [11:0] c_CSR_MCAUSE  = 12'h342;

    // Writeback sequencing states
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_LOAD_WAIT   = 2'd1,
        ST_TRAP        = 2'd2,
        ST_TRAP_COMMIT = 2'd3
    } wbu_state_e;

    // True when the CSR block actually implements the addressed register
    function automatic logic csr_wr_allowed(input logic [11:0] addr);
        return (addr == c_CSR_MSTATUS) || (addr == c_CSR_MTVEC) ||
               (addr == c_CSR_MEPC)    || (addr == c_CSR_MCAUSE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24080014_wbu_perf.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24080014_wbu_perf
//  Brief    : Free-running 64-bit performance counters for the writeback
//             unit: retired instructions and load-wait stall cycles.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_24080014_wbu_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_commit,
    input  logic        i_ld_wait,
    output logic [63:0] o_perf_commits,
    output logic [63:0] o_perf_ld_stall
);

    logic [63:0] r_commits_q;
    logic [63:0] w_commits_d;
    logic [63:0] r_ld_stall_q;
    logic [63:0] w_ld_stall_d;

    // Next counter values; natural 64-bit overflow gives the modulo wrap
    always_comb begin
        w_commits_d  = r_commits_q  + {63'd0, i_commit};
        w_ld_stall_d = r_ld_stall_q + {63'd0, i_ld_wait};
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_commits_q  <= '0;
            r_ld_stall_q <= '0;
        end else begin
            r_commits_q  <= w_commits_d;
            r_ld_stall_q <= w_ld_stall_d;
        end
    end

    assign o_perf_commits  = r_commits_q;
    assign o_perf_ld_stall = r_ld_stall_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_24080014_wbu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_24080014_wbu
//  Brief    : Writeback unit. Accepts retired instructions from EXU, waits for
//             load data, drives GPR/CSR write ports and ecall/mret control,
//             and reports the committed PC and next PC to IFU.
//             Optional counters enabled by YSYX_24080014_WBU_PERF_EN.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_24080014_wbu
    import ysyx_24080014_wbu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int KIND_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [KIND_W-1:0] in_kind,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_dnpc,
    input  logic [4:0]        in_rd,
    input  logic              in_wen,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [11:0]       in_csr_addr,
    input  logic [XLEN-1:0]   in_csr_wdata,
    input  logic              lsu_rvalid,
    input  logic [XLEN-1:0]   lsu_rdata,
    input  logic [XLEN-1:0]   trap_pc,
    output logic              reg_wen,
    output logic [4:0]        reg_rd,
    output logic [XLEN-1:0]   reg_wdata,
    output logic [1:0]        csr_ctl,
    output logic              csr_wen,
    output logic [11:0]       csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              commit_valid,
    output logic [XLEN-1:0]   commit_pc,
    output logic [XLEN-1:0]   commit_dnpc,
    output logic [63:0]       perf_commits,
    output logic [63:0]       perf_ld_stall
);

    wbu_state_e        r_state_q, w_state_d;
    logic [4:0]        r_rd_q, w_rd_d;
    logic [XLEN-1:0]   r_pc_q, w_pc_d;
    logic [XLEN-1:0]   r_dnpc_q, w_dnpc_d;

    logic              r_reg_wen_q, w_reg_wen_d;
    logic [4:0]        r_reg_rd_q, w_reg_rd_d;
    logic [XLEN-1:0]   r_reg_wdata_q, w_reg_wdata_d;
    csr_ctl_e          r_csr_ctl_q, w_csr_ctl_d;
    logic              r_csr_wen_q, w_csr_wen_d;
    logic [11:0]       r_csr_waddr_q, w_csr_waddr_d;
    logic [XLEN-1:0]   r_csr_wdata_q, w_csr_wdata_d;
    logic              r_commit_valid_q, w_commit_valid_d;
    logic [XLEN-1:0]   r_commit_pc_q, w_commit_pc_d;
    logic [XLEN-1:0]   r_commit_dnpc_q, w_commit_dnpc_d;

    logic w_fire;
    logic w_is_load;
    logic w_is_csr;
    logic w_is_ecall;
    logic w_is_mret;
    logic w_alu_wen;

    assign in_ready   = (r_state_q == ST_IDLE);
    assign w_fire     = in_valid & in_ready;
    assign w_is_load  = (in_kind == KIND_W'(KIND_LOAD));
    assign w_is_csr   = (in_kind == KIND_W'(KIND_CSR));
    assign w_is_ecall = (in_kind == KIND_W'(KIND_ECALL));
    assign w_is_mret  = (in_kind == KIND_W'(KIND_MRET));
    // x0 is hard-wired zero, so its writes are dropped while the commit proceeds
    assign w_alu_wen  = in_wen & (in_rd != 5'd0);

    // Next-state and next-output computation; every output defaults to an idle 0
    always_comb begin
        w_state_d        = r_state_q;
        w_rd_d           = r_rd_q;
        w_pc_d           = r_pc_q;
        w_dnpc_d         = r_dnpc_q;
        w_reg_wen_d      = 1'b0;
        w_reg_rd_d       = '0;
        w_reg_wdata_d    = '0;
        w_csr_ctl_d      = CSR_CTL_NONE;
        w_csr_wen_d      = 1'b0;
        w_csr_waddr_d    = '0;
        w_csr_wdata_d    = '0;
        w_commit_valid_d = 1'b0;
        w_commit_pc_d    = '0;
        w_commit_dnpc_d  = '0;
        unique case (r_state_q)
            ST_IDLE: begin
                if (w_fire) begin
                    if (w_is_load) begin
                        w_state_d = ST_LOAD_WAIT;
                        w_rd_d    = in_rd;
                        w_pc_d    = in_pc;
                        w_dnpc_d  = in_dnpc;
                    end else if (w_is_ecall || w_is_mret) begin
                        w_state_d   = ST_TRAP;
                        w_pc_d      = in_pc;
                        w_csr_ctl_d = w_is_ecall ? CSR_CTL_ECALL : CSR_CTL_MRET;
                    end else begin
                        // ALU, CSR and unrecognised kinds retire immediately
                        w_reg_wen_d      = w_alu_wen;
                        w_reg_rd_d       = w_alu_wen ? in_rd : 5'd0;
                        w_reg_wdata_d    = w_alu_wen ? in_wdata : '0;
                        w_commit_valid_d = 1'b1;
                        w_commit_pc_d    = in_pc;
                        w_commit_dnpc_d  = in_dnpc;
                        if (w_is_csr && csr_wr_allowed(in_csr_addr)) begin
                            w_csr_wen_d   = 1'b1;
                            w_csr_waddr_d = in_csr_addr;
                            w_csr_wdata_d = in_csr_wdata;
                        end
                    end
                end
            end
            ST_LOAD_WAIT: begin
                if (lsu_rvalid) begin
                    w_state_d        = ST_IDLE;
                    w_reg_wen_d      = (r_rd_q != 5'd0);
                    w_reg_rd_d       = (r_rd_q != 5'd0) ? r_rd_q : 5'd0;
                    w_reg_wdata_d    = (r_rd_q != 5'd0) ? lsu_rdata : '0;
                    w_commit_valid_d = 1'b1;
                    w_commit_pc_d    = r_pc_q;
                    w_commit_dnpc_d  = r_dnpc_q;
                end
            end
            ST_TRAP: begin
                // csr_ctl was issued last cycle; the CSR block now presents its target
                w_state_d        = ST_TRAP_COMMIT;
                w_commit_valid_d = 1'b1;
                w_commit_pc_d    = r_pc_q;
                w_commit_dnpc_d  = trap_pc;
            end
            ST_TRAP_COMMIT: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched instruction context and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q        <= ST_IDLE;
            r_rd_q           <= '0;
            r_pc_q           <= '0;
            r_dnpc_q         <= '0;
            r_reg_wen_q      <= 1'b0;
            r_reg_rd_q       <= '0;
            r_reg_wdata_q    <= '0;
            r_csr_ctl_q      <= CSR_CTL_NONE;
            r_csr_wen_q      <= 1'b0;
            r_csr_waddr_q    <= '0;
            r_csr_wdata_q    <= '0;
            r_commit_valid_q <= 1'b0;
            r_commit_pc_q    <= '0;
            r_commit_dnpc_q  <= '0;
        end else begin
            r_state_q        <= w_state_d;
            r_rd_q           <= w_rd_d;
            r_pc_q           <= w_pc_d;
            r_dnpc_q         <= w_dnpc_d;
            r_reg_wen_q      <= w_reg_wen_d;
            r_reg_rd_q       <= w_reg_rd_d;
            r_reg_wdata_q    <= w_reg_wdata_d;
            r_csr_ctl_q      <= w_csr_ctl_d;
            r_csr_wen_q      <= w_csr_wen_d;
            r_csr_waddr_q    <= w_csr_waddr_d;
            r_csr_wdata_q    <= w_csr_wdata_d;
            r_commit_valid_q <= w_commit_valid_d;
            r_commit_pc_q    <= w_commit_pc_d;
            r_commit_dnpc_q  <= w_commit_dnpc_d;
        end
    end

    assign reg_wen      = r_reg_wen_q;
    assign reg_rd       = r_reg_rd_q;
    assign reg_wdata    = r_reg_wdata_q;
    assign csr_ctl      = r_csr_ctl_q;
    assign csr_wen      = r_csr_wen_q;
    assign csr_waddr    = r_csr_waddr_q;
    assign csr_wdata    = r_csr_wdata_q;
    assign commit_valid = r_commit_valid_q;
    assign commit_pc    = r_commit_pc_q;
    assign commit_dnpc  = r_commit_dnpc_q;

`ifdef YSYX_24080014_WBU_PERF_EN
    ysyx_24080014_wbu_perf u_perf (
        .clk             (clk),
        .rst             (rst),
        .i_commit        (r_commit_valid_q),
        .i_ld_wait       (r_state_q == ST_LOAD_WAIT),
        .o_perf_commits  (perf_commits),
        .o_perf_ld_stall (perf_ld_stall)
    );
`else
    assign perf_commits  = '0;
    assign perf_ld_stall = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24080014_wbu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_24080014_wbu
//  Brief    : Self-checking bench for the writeback unit: directed vector
//             table, hand sequences for back-to-back issue and reset during
//             a load, and randomized instructions against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_24080014_wbu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_kind;
    logic [31:0] in_pc;
    logic [31:0] in_dnpc;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [31:0] in_wdata;
    logic [11:0] in_csr_addr;
    logic [31:0] in_csr_wdata;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic [31:0] trap_pc;
    logic        reg_wen;
    logic [4:0]  reg_rd;
    logic [31:0] reg_wdata;
    logic [1:0]  csr_ctl;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_dnpc;
    logic [63:0] perf_commits;
    logic [63:0] perf_ld_stall;

    ysyx_24080014_wbu #(.XLEN(32), .KIND_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_pc(in_pc), .in_dnpc(in_dnpc), .in_rd(in_rd),
        .in_wen(in_wen), .in_wdata(in_wdata), .in_csr_addr(in_csr_addr),
        .in_csr_wdata(in_csr_wdata), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .trap_pc(trap_pc), .reg_wen(reg_wen), .reg_rd(reg_rd), .reg_wdata(reg_wdata),
        .csr_ctl(csr_ctl), .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_dnpc(commit_dnpc),
        .perf_commits(perf_commits), .perf_ld_stall(perf_ld_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] pc;
        logic [31:0] dnpc;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] wdata;
        logic [11:0] csr_addr;
        logic [31:0] csr_wdata;
        int          lat;
        logic [31:0] ldata;
        logic [31:0] tpc;
        logic        exp_reg_wen;
        logic [31:0] exp_reg_wdata;
        logic        exp_csr_wen;
        logic [1:0]  exp_csr_ctl;
        logic [31:0] exp_dnpc;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_commits = 64'd0;
    logic [63:0] exp_stall   = 64'd0;
    vec_t        tbl[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] kind, input logic [31:0] pc, input logic [31:0] dnpc,
                                input logic [4:0] rd, input logic wen, input logic [31:0] wdata,
                                input logic [11:0] caddr, input logic [31:0] cwdata, input int lat,
                                input logic [31:0] ldata, input logic [31:0] tpc, input logic ewen,
                                input logic [31:0] ewdata, input logic ecwen, input logic [1:0] ectl,
                                input logic [31:0] ednpc);
        vec_t v;
        v.kind = kind; v.pc = pc; v.dnpc = dnpc; v.rd = rd; v.wen = wen; v.wdata = wdata;
        v.csr_addr = caddr; v.csr_wdata = cwdata; v.lat = lat; v.ldata = ldata; v.tpc = tpc;
        v.exp_reg_wen = ewen; v.exp_reg_wdata = ewdata; v.exp_csr_wen = ecwen;
        v.exp_csr_ctl = ectl; v.exp_dnpc = ednpc;
        return v;
    endfunction

    // Reference model: what the instruction must produce, from its kind and operands
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit is_load, is_trap, is_csr;
        r       = v;
        is_load = (v.kind == 3'd1);
        is_csr  = (v.kind == 3'd2);
        is_trap = (v.kind == 3'd3) || (v.kind == 3'd4);
        r.exp_reg_wen   = !is_trap && (v.rd != 5'd0) && (is_load || v.wen);
        r.exp_reg_wdata = is_load ? v.ldata : v.wdata;
        r.exp_csr_wen   = is_csr && (v.csr_addr inside {12'h300, 12'h305, 12'h341, 12'h342});
        r.exp_csr_ctl   = (v.kind == 3'd3) ? 2'b01 : (v.kind == 3'd4) ? 2'b10 : 2'b00;
        r.exp_dnpc      = is_trap ? v.tpc : v.dnpc;
        return r;
    endfunction

    // Issue one instruction from idle and check every cycle until it retires
    task automatic run(input vec_t v);
        bit is_load, is_trap;
        is_load = (v.kind == 3'd1);
        is_trap = (v.kind == 3'd3) || (v.kind == 3'd4);
        chk("ready_before_issue", in_ready, 1);
        in_valid = 1'b1; in_kind = v.kind; in_pc = v.pc; in_dnpc = v.dnpc; in_rd = v.rd;
        in_wen = v.wen; in_wdata = v.wdata; in_csr_addr = v.csr_addr; in_csr_wdata = v.csr_wdata;
        trap_pc = v.tpc;
        // stray load data in the accept cycle must be ignored
        lsu_rvalid = 1'b1; lsu_rdata = ~v.ldata;
        step();
        in_valid = 1'b0; lsu_rvalid = 1'b0;
        if (is_load) begin
            for (int c = 1; c <= v.lat; c++) begin
                chk("ldwait_ready", in_ready, 0);
                chk("ldwait_commit", commit_valid, 0);
                chk("ldwait_reg_wen", reg_wen, 0);
                if (c == v.lat) begin
                    lsu_rvalid = 1'b1; lsu_rdata = v.ldata;
                end
                step();
            end
            lsu_rvalid = 1'b0;
            exp_stall += 64'(v.lat);
        end else if (is_trap) begin
            chk("trap_csr_ctl", csr_ctl, v.exp_csr_ctl);
            chk("trap_reg_wen", reg_wen, 0);
            chk("trap_early_commit", commit_valid, 0);
            chk("trap_ready", in_ready, 0);
            step();
            chk("trap_ctl_cleared", csr_ctl, 0);
            chk("trap_commit_ready", in_ready, 0);
        end else begin
            chk("alu_csr_ctl", csr_ctl, 0);
            chk("alu_ready", in_ready, 1);
        end
        chk("commit_valid", commit_valid, 1);
        chk("commit_pc", commit_pc, v.pc);
        chk("commit_dnpc", commit_dnpc, v.exp_dnpc);
        chk("reg_wen", reg_wen, v.exp_reg_wen);
        if (v.exp_reg_wen) begin
            chk("reg_rd", reg_rd, v.rd);
            chk("reg_wdata", reg_wdata, v.exp_reg_wdata);
        end
        chk("csr_wen", csr_wen, v.exp_csr_wen);
        if (v.exp_csr_wen) begin
            chk("csr_waddr", csr_waddr, v.csr_addr);
            chk("csr_wdata", csr_wdata, v.csr_wdata);
        end
        exp_commits += 64'd1;
        if (is_trap) begin
            step();
            chk("trap_done_ready", in_ready, 1);
            chk("trap_done_commit", commit_valid, 0);
        end
    endtask

    task automatic check_perf(input string tag);
`ifdef YSYX_24080014_WBU_PERF_EN
        chk({tag, "_perf_commits"}, perf_commits, exp_commits);
        chk({tag, "_perf_ld_stall"}, perf_ld_stall, exp_stall);
`else
        chk({tag, "_perf_commits"}, perf_commits, 64'd0);
        chk({tag, "_perf_ld_stall"}, perf_ld_stall, 64'd0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; lsu_rvalid = 1'b0;
        step();
        step();
        chk("rst_ready", in_ready, 1);
        chk("rst_reg_wen", reg_wen, 0);
        chk("rst_commit", commit_valid, 0);
        chk("rst_csr_wen", csr_wen, 0);
        chk("rst_csr_ctl", csr_ctl, 0);
        chk("rst_commit_dnpc", commit_dnpc, 0);
        exp_commits = 64'd0; exp_stall = 64'd0;
        check_perf("rst");
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_kind = 3'd0; in_pc = '0; in_dnpc = '0; in_rd = '0;
        in_wen = 1'b0; in_wdata = '0; in_csr_addr = '0; in_csr_wdata = '0;
        lsu_rvalid = 1'b0; lsu_rdata = '0; trap_pc = '0;

        tbl[0] = mk(3'd0, 32'h8000_0000, 32'h8000_0004, 5'd0,  1'b1, 32'h0000_FFFF, 12'h000, 32'h0, 0, 32'h0,
                    32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h8000_0004);
        tbl[1] = mk(3'd1, 32'h8000_0004, 32'h8000_0008, 5'd10, 1'b1, 32'h0000_1234, 12'h000, 32'h0, 3, 32'hDEAD_BEEF,
                    32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00, 32'h8000_0008);
        tbl[2] = mk(3'd3, 32'h8000_0010, 32'h8000_0014, 5'd0,  1'b0, 32'h0, 12'h000, 32'h0, 0, 32'h0,
                    32'h8000_0100, 1'b0, 32'h0, 1'b0, 2'b01, 32'h8000_0100);
        tbl[3] = mk(3'd4, 32'h8000_0100, 32'h8000_0104, 5'd0,  1'b0, 32'h0, 12'h000, 32'h0, 0, 32'h0,
                    32'h8000_0014, 1'b0, 32'h0, 1'b0, 2'b10, 32'h8000_0014);
        tbl[4] = mk(3'd2, 32'h8000_0020, 32'h8000_0024, 5'd7,  1'b1, 32'h0, 12'h305, 32'h8000_0200, 0, 32'h0,
                    32'h0, 1'b1, 32'h0, 1'b1, 2'b00, 32'h8000_0024);
        tbl[5] = mk(3'd2, 32'h8000_0024, 32'h8000_0028, 5'd8,  1'b1, 32'h0000_00AA, 12'h7C0, 32'h55, 0, 32'h0,
                    32'h0, 1'b1, 32'h0000_00AA, 1'b0, 2'b00, 32'h8000_0028);
        tbl[6] = mk(3'd7, 32'h8000_0028, 32'h8000_1000, 5'd31, 1'b1, 32'hCAFE_F00D, 12'h300, 32'h1, 0, 32'h0,
                    32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 2'b00, 32'h8000_1000);
        tbl[7] = mk(3'd1, 32'h8000_0030, 32'h8000_0034, 5'd0,  1'b1, 32'h0, 12'h000, 32'h0, 1, 32'h1234_5678,
                    32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h8000_0034);
        tbl[8] = mk(3'd0, 32'h8000_0034, 32'h8000_0038, 5'd3,  1'b0, 32'h0000_0077, 12'h000, 32'h0, 0, 32'h0,
                    32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h8000_0038);
        tbl[9] = mk(3'd2, 32'h8000_0038, 32'h8000_003C, 5'd0,  1'b0, 32'h0, 12'h342, 32'h0000_000B, 0, 32'h0,
                    32'h0, 1'b0, 32'h0, 1'b1, 2'b00, 32'h8000_003C);

        do_reset();

        // Back-to-back ALU instructions: one per cycle, ready never drops
        in_valid = 1'b1; in_kind = 3'd0; in_wen = 1'b1; in_rd = 5'd5; in_wdata = 32'h11;
        in_pc = 32'h8000_0040; in_dnpc = 32'h8000_0044;
        step();
        chk("b2b0_reg_wen", reg_wen, 1);
        chk("b2b0_reg_rd", reg_rd, 5);
        chk("b2b0_reg_wdata", reg_wdata, 32'h11);
        chk("b2b0_commit", commit_valid, 1);
        chk("b2b0_ready", in_ready, 1);
        in_rd = 5'd6; in_wdata = 32'h22; in_pc = 32'h8000_0044; in_dnpc = 32'h8000_0048;
        step();
        in_valid = 1'b0;
        chk("b2b1_reg_wen", reg_wen, 1);
        chk("b2b1_reg_rd", reg_rd, 6);
        chk("b2b1_reg_wdata", reg_wdata, 32'h22);
        chk("b2b1_commit", commit_valid, 1);
        chk("b2b1_commit_dnpc", commit_dnpc, 32'h8000_0048);
        chk("b2b1_ready", in_ready, 1);
        exp_commits += 64'd2;
        step();
        chk("b2b_idle_commit", commit_valid, 0);
        chk("b2b_idle_reg_wen", reg_wen, 0);

        for (int i = 0; i < 10; i++) run(tbl[i]);
        step();
        check_perf("table");

        // Single 3-cycle load from a clean counter state
        do_reset();
        run(tbl[1]);
        step();
        check_perf("load3");

        for (int i = 0; i < 60; i++) begin
            vec_t v;
            logic [31:0] r;
            r = $urandom;
            v.kind = r[2:0]; v.rd = r[7:3]; v.wen = r[8];
            v.pc = $urandom & 32'hFFFF_FFFC; v.dnpc = $urandom & 32'hFFFF_FFFC;
            v.wdata = $urandom; v.csr_wdata = $urandom; v.ldata = $urandom;
            v.tpc = $urandom & 32'hFFFF_FFFC;
            v.lat = int'($urandom_range(1, 4));
            case ($urandom_range(0, 4))
                0: v.csr_addr = 12'h300;
                1: v.csr_addr = 12'h305;
                2: v.csr_addr = 12'h341;
                3: v.csr_addr = 12'h342;
                default: v.csr_addr = r[31:20];
            endcase
            if (v.kind == 3'd1) v.wen = 1'b1;
            run(model(v));
        end
        step();
        check_perf("random");

        // Reset while waiting for load data: the load must vanish
        do_reset();
        in_valid = 1'b1; in_kind = 3'd1; in_rd = 5'd10; in_wen = 1'b1;
        in_pc = 32'h8000_0050; in_dnpc = 32'h8000_0054;
        step();
        in_valid = 1'b0;
        chk("rstld_wait_ready", in_ready, 0);
        step();
        rst = 1'b1; lsu_rvalid = 1'b1; lsu_rdata = 32'hDEAD_BEEF;
        step();
        chk("rstld_reg_wen", reg_wen, 0);
        chk("rstld_commit", commit_valid, 0);
        chk("rstld_ready", in_ready, 1);
        rst = 1'b0;
        step();
        lsu_rvalid = 1'b0;
        chk("rstld_after_reg_wen", reg_wen, 0);
        chk("rstld_after_commit", commit_valid, 0);
        chk("rstld_after_ready", in_ready, 1);
        exp_commits = 64'd0; exp_stall = 64'd0;
        step();
        chk("rstld_late_commit", commit_valid, 0);
        check_perf("rstld");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_24080014_wbu.md
Name: ysyx_24080014_wbu

Overview:
- Writeback unit: the write-side driver of the register file / CSR block.
- Accepts one retired instruction per handshake from EXU and waits for LSU load data when needed.
- Drives the GPR write port, CSR write port and ecall/mret control.
- Returns the committed PC and next PC to IFU, including the trap target sampled back from the CSR block.

Parameters:
- XLEN, 32, data/PC width
- KIND_W, 3, width of instruction-kind field

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  EXU request valid
- in_ready  out  1  WBU can accept
- in_kind  in  KIND_W  0=ALU 1=LOAD 2=CSR 3=ECALL 4=MRET; others treated as ALU
- in_pc  in  XLEN  instruction PC
- in_dnpc  in  XLEN  sequential/branch next PC
- in_rd  in  5  destination index
- in_wen  in  1  instruction writes rd
- in_wdata  in  XLEN  ALU result or old CSR value
- in_csr_addr  in  12  CSR to write (kind=CSR)
- in_csr_wdata  in  XLEN  new CSR value
- lsu_rvalid  in  1  load data valid, one-cycle pulse
- lsu_rdata  in  XLEN  load data
- trap_pc  in  XLEN  csr_next_pc from register file
- reg_wen  out  1  GPR write enable
- reg_rd  out  5  GPR write index
- reg_wdata  out  XLEN  GPR write data
- csr_ctl  out  2  00 none, 01 ecall, 10 mret
- csr_wen  out  1  CSR write enable
- csr_waddr  out  12  CSR address
- csr_wdata  out  XLEN  CSR data
- commit_valid  out  1  one-cycle retire pulse
- commit_pc  out  XLEN  retired PC
- commit_dnpc  out  XLEN  PC IFU must fetch next
- perf_commits  out  64  retired count (feature)
- perf_ld_stall  out  64  LOAD_WAIT cycles (feature)

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset: state IDLE. All outputs 0 except in_ready. in_ready = 1 in IDLE. Pending load or trap discarded.
- All write/commit outputs are registered, one-cycle pulses, 0 otherwise. Handshake = in_valid & in_ready. in_ready = (state==IDLE).
- ALU, accepted cycle N:
  - N+1: reg_wen = in_wen & (in_rd != 0), reg_rd/reg_wdata, commit_valid = 1, commit_dnpc = in_dnpc.
  - Stays IDLE, so back-to-back throughput is 1/cycle.
- CSR: as ALU, plus csr_wen = 1 with csr_waddr/csr_wdata in the same N+1 cycle.
  - Only addresses 0x300, 0x305, 0x341, 0x342 assert csr_wen; any other address suppresses csr_wen but still commits.
- LOAD: go to LOAD_WAIT with rd, pc and dnpc latched.
  - On the cycle M with lsu_rvalid: M+1 reg_wen (rd != 0), reg_wdata = lsu_rdata, commit_valid, return to IDLE.
  - lsu_rvalid in the same cycle as the accept is ignored; data must arrive at N+1 or later.
- ECALL/MRET: go to TRAP.
  - N+1: csr_ctl = 01/10 for one cycle, reg_wen = 0.
  - N+2: state TRAP_COMMIT. Sample trap_pc, set commit_valid, commit_dnpc = trap_pc, return to IDLE.
- lsu_rvalid outside LOAD_WAIT is ignored.
- rst asserted in any state overrides all events in that cycle.
- Writes to rd=0 are never issued, but the instruction still commits.

Optional Feature:
- Macro YSYX_24080014_WBU_PERF_EN.
- Defined:
  - perf_commits increments on every commit_valid.
  - perf_ld_stall increments on every LOAD_WAIT cycle.
  - Both cleared by rst and wrap modulo 2^64.
- Undefined: both ports tied to 0 and no counter flops are inferred.

Decomposition:
- Package ysyx_24080014_wbu_pkg:
  - kind enum
  - csr_ctl encodings (NONE/ECALL/MRET)
  - CSR address constants MSTATUS=0x300, MTVEC=0x305, MEPC=0x341, MCAUSE=0x342
  - state enum (IDLE, LOAD_WAIT, TRAP, TRAP_COMMIT)
- Sub-module ysyx_24080014_wbu_perf holds the two counters, instantiated only under the macro.

Test Plan:
- ALU back-to-back: (rd=5, 0x11) then (rd=6, 0x22) on consecutive cycles -> reg_wen in the next two cycles with matching data, in_ready stays 1, two commits.
- ALU rd=0, wdata 0xFFFF -> reg_wen = 0, commit_valid = 1 with commit_dnpc = in_dnpc.
- LOAD rd=10, lsu_rvalid 3 cycles later with 0xDEADBEEF -> in_ready = 0 during wait, reg_wen one cycle after rvalid, x10 = 0xDEADBEEF; perf_ld_stall = 3 with macro.
- ECALL pc=0x80000010, trap_pc=0x80000100 -> csr_ctl = 01 at N+1, commit_dnpc = 0x80000100 at N+2; MRET analogous with csr_ctl = 10.
- CSR 0x305 with wdata 0x80000200, rd=7, old value 0x0 -> csr_wen and reg_wen in the same cycle; address 0x7C0 -> csr_wen = 0, commit still occurs.
- rst asserted mid LOAD_WAIT, then lsu_rvalid -> no reg_wen, no commit, in_ready = 1 the cycle after reset deasserts.
